// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: two-flop synchroniser, oversampling FSM, FWFT byte FIFO and sticky error flags.
// fsm_state is a debug view of the receiver: 0 IDLE, 1 START, 2 DATA, 3 STOP, 4 BREAK.
module uart_rx_fifo #(
   parameter int CLOCK_FREQ = 27000000,
   parameter int BIT_RATE   = 9600,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        rx,
   input  logic                        rd_en,
   input  logic                        clr_err,
   output logic [7:0]                  rd_data,
   output logic                        empty,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        frame_error,
   output logic                        overrun,
   output logic [2:0]                  fsm_state
);
   localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam int PW           = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] LAST_HALF = CW'(HALF_BIT - 1);
   localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   logic          rx_meta_q, rxs_q;
   state_t        state_q, state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          push_q, push_d;
   logic          fe_set;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          empty_q, full_q, fe_q, ovr_q;
   logic          do_pop, do_push, ovr_set;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         push_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         push_q    <= push_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      push_d    = 1'b0;
      fe_set    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxs_q) begin
               state_d   = START;
               clk_cnt_d = '0;
            end
         end
         START: begin
            // Mid-start-bit check: a line that is high again was only a glitch.
            if (clk_cnt_q == LAST_HALF) begin
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = rxs_q ? IDLE : DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (clk_cnt_q == LAST_CLK) begin
               clk_cnt_d = '0;
               shift_d   = {rxs_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (clk_cnt_q == LAST_CLK) begin
               clk_cnt_d = '0;
               if (rxs_q) begin
                  push_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  fe_set  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         BREAK: begin
            if (rxs_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A pop in the push cycle frees a slot, so a full FIFO still accepts the byte.
   assign do_pop  = rd_en & ~empty_q;
   assign do_push = push_q & (~full_q | do_pop);
   assign ovr_set = push_q & ~do_push;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         fe_q     <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= (count_d == '0);
         full_q   <= (count_d == DEPTH_CNT);
         fe_q     <= fe_set  | (fe_q  & ~clr_err);
         ovr_q    <= ovr_set | (ovr_q & ~clr_err);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= shift_q;
   end

   assign rd_data     = empty_q ? 8'h00 : mem[rd_ptr_q];
   assign empty       = empty_q;
   assign full        = full_q;
   assign count       = count_q;
   assign frame_error = fe_q;
   assign overrun     = ovr_q;
   assign fsm_state   = state_q;

endmodule
